// File: rtl/item_run_coalescer_pkg.sv
// Shared definitions for the item run coalescer.
//  - Default key/counter widths, common with merge_query.
//  - FSM state encoding: EMPTY=0, RUN=1, DRAIN=2.
//  - cnt_max(): largest record count for a given merge_query counter width.
package item_run_coalescer_pkg;

  localparam int DEF_ITEM_LENGTH       = 48;
  localparam int DEF_ITEM_COUNTER_SIZE = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    RUN   = 2'd1,  // record open, accumulating matching items
    DRAIN = 2'd2   // record sealed, waiting for a non-full queue
  } state_e;

  // Record counts use ITEM_COUNTER_SIZE-1 bits, so MAX = 2^(ITEM_COUNTER_SIZE-1)-1.
  function automatic int cnt_max(input int item_counter_size);
    return (1 << (item_counter_size - 1)) - 1;
  endfunction

endpackage

// File: rtl/item_run_coalescer_if.sv
// Bundle of the raw-stream and merge-queue signals around the coalescer.
//  master : drives raw_valid/raw_item/flush/queue_full_signal, observes the rest
//  slave  : the coalescer itself
//  raw_valid/raw_item/raw_ready : raw item valid/ready stream
//  flush                        : level, seal and drain the held record
//  queue_full_signal            : merge_query full, no write while high
//  valid_out/item_out/item_counter_out : record write into merge_query
//  busy                         : a record is held
interface item_run_coalescer_if
  import item_run_coalescer_pkg::*;
#(
  parameter int ITEM_LENGTH       = DEF_ITEM_LENGTH,
  parameter int ITEM_COUNTER_SIZE = DEF_ITEM_COUNTER_SIZE
);
  logic                         raw_valid;
  logic [ITEM_LENGTH-1:0]       raw_item;
  logic                         raw_ready;
  logic                         flush;
  logic                         queue_full_signal;
  logic                         valid_out;
  logic [ITEM_LENGTH-1:0]       item_out;
  logic [ITEM_COUNTER_SIZE-2:0] item_counter_out;
  logic                         busy;

  modport master (
    output raw_valid, raw_item, flush, queue_full_signal,
    input  raw_ready, valid_out, item_out, item_counter_out, busy
  );

  modport slave (
    input  raw_valid, raw_item, flush, queue_full_signal,
    output raw_ready, valid_out, item_out, item_counter_out, busy
  );
endinterface

// File: rtl/item_run_coalescer.sv
// Collapses runs of identical raw items into (item, count) records and writes
// them into merge_query, respecting queue_full_signal.
//  clk, rst_n : clock (rising edge), async active-low reset
//  bus        : item_run_coalescer_if.slave (raw stream in, record writes out)
// item_out/item_counter_out come straight from the hold registers; valid_out
// and raw_ready are combinational so a record can be emitted and a new one
// loaded on the same edge.
module item_run_coalescer
  import item_run_coalescer_pkg::*;
#(
  parameter int ITEM_LENGTH       = DEF_ITEM_LENGTH,
  parameter int ITEM_COUNTER_SIZE = DEF_ITEM_COUNTER_SIZE,
  parameter int IDLE_TIMEOUT      = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  item_run_coalescer_if.slave bus
);

  localparam int CW = ITEM_COUNTER_SIZE - 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(cnt_max(ITEM_COUNTER_SIZE));
  localparam logic [CW-1:0] CNT_PENULT = CNT_MAX - 1'b1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [ITEM_LENGTH-1:0] item_q,  item_d;
  logic [CW-1:0]          cnt_q,   cnt_d;
  logic [IW-1:0]          idle_q,  idle_d;

  logic ready, acc, match;

  assign acc   = bus.raw_valid & bus.raw_ready;
  assign match = (bus.raw_item == item_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      item_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      item_q  <= item_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = RUN;
          item_d  = bus.raw_item;
          cnt_d   = CW'(1);
          idle_d  = '0;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else if (acc && match) begin
          // Reaching MAX seals the record so the count can never wrap.
          if (cnt_q == CNT_PENULT) state_d = DRAIN;
          cnt_d  = cnt_q + 1'b1;
          idle_d = '0;
        end else if (acc) begin
          // Mismatch accepted: old record leaves via valid_out this cycle.
          item_d = bus.raw_item;
          cnt_d  = CW'(1);
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.queue_full_signal) begin
          if (acc) begin
            state_d = RUN;
            item_d  = bus.raw_item;
            cnt_d   = CW'(1);
            idle_d  = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    ready         = 1'b0;
    bus.valid_out = 1'b0;
    case (state_q)
      EMPTY: ready = !bus.flush;
      RUN: begin
        if (!bus.flush) begin
          if (bus.raw_valid && !match) begin
            // A new key can only enter if the held record can be written out.
            ready         = !bus.queue_full_signal;
            bus.valid_out = !bus.queue_full_signal;
          end else begin
            ready = 1'b1;
          end
        end
      end
      DRAIN: begin
        ready         = !bus.queue_full_signal && !bus.flush;
        bus.valid_out = !bus.queue_full_signal;
      end
      default: ;
    endcase
  end

  assign bus.raw_ready        = rst_n & ready;
  assign bus.item_out         = item_q;
  assign bus.item_counter_out = cnt_q;
  assign bus.busy             = (state_q != EMPTY);

endmodule
